// File: rtl/pll_reconfig_writer.sv
// pll_reconfig_writer
// Avalon-MM master that reprograms a fractional PLL through its reconfiguration
// management port: mode, N, M, K, NUM_CLK C counters, then start. After start
// it waits for the synchronised lock (16-cycle blanking, LOCK_TIMEOUT budget)
// and reports done or a sticky error.
// Optional build macro PLL_RECONF_READBACK_EN: reads back N, M and K after
// writing them and aborts with error (no start) on any mismatch.
module pll_reconfig_writer #(
    parameter int NUM_CLK      = 3,
    parameter int LOCK_TIMEOUT = 1000000,
    parameter int ADDR_W       = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic [17:0]             n_cnt,
    input  logic [17:0]             m_cnt,
    input  logic [31:0]             k_frac,
    input  logic [18*NUM_CLK-1:0]   c_cnt,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    input  logic                    pll_locked,
    output logic [ADDR_W-1:0]       mgmt_address,
    output logic                    mgmt_write,
    output logic                    mgmt_read,
    output logic [31:0]             mgmt_writedata,
    input  logic [31:0]             mgmt_readdata,
    input  logic                    mgmt_waitrequest
);

    // Lock counter is wide enough for the timeout and for the blanking window.
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 32);
    localparam int C_W   = 18 * NUM_CLK;

    localparam logic [CNT_W-1:0]  BLANK_CYC = CNT_W'(32'd16);
    localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [4:0]        C_LAST    = 5'(NUM_CLK - 1);

    // Management register map of the reconfiguration block.
    localparam logic [ADDR_W-1:0] A_MODE  = ADDR_W'(32'd0);
    localparam logic [ADDR_W-1:0] A_START = ADDR_W'(32'd2);
    localparam logic [ADDR_W-1:0] A_N     = ADDR_W'(32'd3);
    localparam logic [ADDR_W-1:0] A_M     = ADDR_W'(32'd4);
    localparam logic [ADDR_W-1:0] A_C     = ADDR_W'(32'd5);
    localparam logic [ADDR_W-1:0] A_K     = ADDR_W'(32'd7);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_MODE,
        S_WR_N,
        S_WR_M,
        S_WR_K,
`ifdef PLL_RECONF_READBACK_EN
        S_RD_N,
        S_RD_M,
        S_RD_K,
`endif
        S_WR_C,
        S_START,
        S_WAIT_LOCK,
        S_DONE,
        S_ERR
    } state_t;

    // C counter register word: counter index in [22:18], counter value in [17:0].
    function automatic logic [31:0] c_word(input logic [4:0] idx, input logic [17:0] val);
        return {9'b0, idx, val};
    endfunction

    // Registered state and outputs
    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               write_q, write_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic [17:0]        n_q, n_d;
    logic [17:0]        m_q, m_d;
    logic [31:0]        k_q, k_d;
    logic [C_W-1:0]     c_q, c_d;
    logic [4:0]         c_idx_q, c_idx_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic               lock_meta_q, lock_sync_q;

    // Decoded write target for the current write state
    logic [ADDR_W-1:0]  wr_addr_s;
    logic [31:0]        wr_data_s;
    state_t             wr_next_s;
    logic [17:0]        c_sel_s;

`ifdef PLL_RECONF_READBACK_EN
    logic               read_q, read_d;
    logic [ADDR_W-1:0]  rd_addr_s;
    logic               rd_ok_s;
    state_t             rd_next_s;
`else
    logic               unused_readdata_s;
    assign unused_readdata_s = ^mgmt_readdata;
`endif

    // Select the captured C counter addressed by the running index.
    always_comb begin
        c_sel_s = 18'd0;
        for (int i = 0; i < NUM_CLK; i++) begin
            c_sel_s = (c_idx_q == 5'(i)) ? c_q[18*i +: 18] : c_sel_s;
        end
    end

    // Address, data and successor state of each write state.
    always_comb begin
        wr_addr_s = A_MODE;
        wr_data_s = 32'd0;
        wr_next_s = S_IDLE;
        case (state_q)
            S_WR_MODE: begin
                wr_addr_s = A_MODE;
                wr_data_s = 32'd0;
                wr_next_s = S_WR_N;
            end
            S_WR_N: begin
                wr_addr_s = A_N;
                wr_data_s = {14'd0, n_q};
                wr_next_s = S_WR_M;
            end
            S_WR_M: begin
                wr_addr_s = A_M;
                wr_data_s = {14'd0, m_q};
                wr_next_s = S_WR_K;
            end
            S_WR_K: begin
                wr_addr_s = A_K;
                wr_data_s = k_q;
`ifdef PLL_RECONF_READBACK_EN
                wr_next_s = S_RD_N;
`else
                wr_next_s = S_WR_C;
`endif
            end
            S_WR_C: begin
                wr_addr_s = A_C;
                wr_data_s = c_word(c_idx_q, c_sel_s);
                wr_next_s = (c_idx_q == C_LAST) ? S_START : S_WR_C;
            end
            S_START: begin
                wr_addr_s = A_START;
                wr_data_s = 32'd1;
                wr_next_s = S_WAIT_LOCK;
            end
            default: begin
                wr_addr_s = A_MODE;
                wr_data_s = 32'd0;
                wr_next_s = S_IDLE;
            end
        endcase
    end

`ifdef PLL_RECONF_READBACK_EN
    // Address, readback check and successor state of each read state.
    always_comb begin
        rd_addr_s = A_N;
        rd_ok_s   = 1'b0;
        rd_next_s = S_IDLE;
        case (state_q)
            S_RD_N: begin
                rd_addr_s = A_N;
                rd_ok_s   = (mgmt_readdata[17:0] == n_q);
                rd_next_s = S_RD_M;
            end
            S_RD_M: begin
                rd_addr_s = A_M;
                rd_ok_s   = (mgmt_readdata[17:0] == m_q);
                rd_next_s = S_RD_K;
            end
            S_RD_K: begin
                rd_addr_s = A_K;
                rd_ok_s   = (mgmt_readdata == k_q);
                rd_next_s = S_WR_C;
            end
            default: begin
                rd_addr_s = A_N;
                rd_ok_s   = 1'b0;
                rd_next_s = S_IDLE;
            end
        endcase
    end
`endif

    // Next-state and next-output logic of the sequencer.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        write_d    = write_q;
        addr_d     = addr_q;
        data_d     = data_q;
        n_d        = n_q;
        m_d        = m_q;
        k_d        = k_q;
        c_d        = c_q;
        c_idx_d    = c_idx_q;
        lock_cnt_d = lock_cnt_q;
`ifdef PLL_RECONF_READBACK_EN
        read_d     = read_q;
`endif
        case (state_q)
            S_IDLE: begin
                write_d = 1'b0;
                if (req) begin
                    n_d     = n_cnt;
                    m_d     = m_cnt;
                    k_d     = k_frac;
                    c_d     = c_cnt;
                    c_idx_d = 5'd0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_WR_MODE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_MODE, S_WR_N, S_WR_M, S_WR_K, S_WR_C, S_START: begin
                if (!write_q) begin
                    // Issue phase: present address, data and strobe together.
                    write_d = 1'b1;
                    addr_d  = wr_addr_s;
                    data_d  = wr_data_s;
                end else if (!mgmt_waitrequest) begin
                    // Completion edge: drop the strobe and move on.
                    write_d    = 1'b0;
                    state_d    = wr_next_s;
                    c_idx_d    = (state_q == S_WR_C) ? (c_idx_q + 5'd1) : c_idx_q;
                    lock_cnt_d = {CNT_W{1'b0}};
                end else begin
                    write_d = 1'b1;
                end
            end
`ifdef PLL_RECONF_READBACK_EN
            S_RD_N, S_RD_M, S_RD_K: begin
                if (!read_q) begin
                    read_d = 1'b1;
                    addr_d = rd_addr_s;
                end else if (!mgmt_waitrequest) begin
                    read_d = 1'b0;
                    if (rd_ok_s) begin
                        state_d = rd_next_s;
                    end else begin
                        // Readback disagrees: abort before START.
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end else begin
                    read_d = 1'b1;
                end
            end
`endif
            S_WAIT_LOCK: begin
                if ((lock_cnt_q >= BLANK_CYC) && lock_sync_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_ERR;
                end else begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(32'd1);
                end
            end
            S_DONE: begin
                // req is not accepted here, so a req coincident with done is dropped.
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                write_d = 1'b0;
`ifdef PLL_RECONF_READBACK_EN
                read_d  = 1'b0;
`endif
            end
        endcase
    end

    // State, output, capture and lock-synchroniser registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            data_q      <= 32'd0;
            n_q         <= 18'd0;
            m_q         <= 18'd0;
            k_q         <= 32'd0;
            c_q         <= {C_W{1'b0}};
            c_idx_q     <= 5'd0;
            lock_cnt_q  <= {CNT_W{1'b0}};
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
`ifdef PLL_RECONF_READBACK_EN
            read_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            n_q         <= n_d;
            m_q         <= m_d;
            k_q         <= k_d;
            c_q         <= c_d;
            c_idx_q     <= c_idx_d;
            lock_cnt_q  <= lock_cnt_d;
            lock_meta_q <= pll_locked;
            lock_sync_q <= lock_meta_q;
`ifdef PLL_RECONF_READBACK_EN
            read_q      <= read_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign mgmt_write     = write_q;
    assign mgmt_address   = addr_q;
    assign mgmt_writedata = data_q;
`ifdef PLL_RECONF_READBACK_EN
    assign mgmt_read      = read_q;
`else
    assign mgmt_read      = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reconfig_writer.sv
// Directed bench for pll_reconfig_writer: reset values, exact write order,
// waitrequest stalls, lock wait / done, lock timeout, reset mid-write and,
// when PLL_RECONF_READBACK_EN is defined, a readback mismatch abort.
module tb_pll_reconfig_writer;

    localparam int NUM_CLK      = 3;
    localparam int LOCK_TIMEOUT = 100;
    localparam int ADDR_W       = 6;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   req = 1'b0;
    logic [17:0]            n_cnt = 18'd0;
    logic [17:0]            m_cnt = 18'd0;
    logic [31:0]            k_frac = 32'd0;
    logic [18*NUM_CLK-1:0]  c_cnt = '0;
    logic                   busy, done, error;
    logic                   pll_locked = 1'b0;
    logic [ADDR_W-1:0]      mgmt_address;
    logic                   mgmt_write, mgmt_read;
    logic [31:0]            mgmt_writedata;
    logic [31:0]            mgmt_readdata;
    logic                   waitreq = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    // Bench-side bus state
    logic [5:0]  log_addr [$];
    logic [31:0] log_data [$];
    logic [31:0] regs [0:63];
    logic        corrupt_m = 1'b0;
    logic        stall_en = 1'b0;
    logic        stab_en = 1'b0;
    logic        hold_at_m = 1'b0;
    int          strobe_cycles = 0;
    int          done_count = 0;
    int          stall_left = 0;
    logic        armed = 1'b0;
    logic        prev_stall = 1'b0;
    logic [5:0]  prev_addr = 6'd0;
    logic [31:0] prev_data = 32'd0;

    logic [5:0]  exp_a [8] = '{6'd0, 6'd3, 6'd4, 6'd7, 6'd5, 6'd5, 6'd5, 6'd2};
    logic [31:0] exp_d [8] = '{32'h0, 32'h404, 32'h808, 32'h80000000,
                               32'h00202, 32'h40404, 32'hA0101, 32'h1};

    pll_reconfig_writer #(
        .NUM_CLK(NUM_CLK), .LOCK_TIMEOUT(LOCK_TIMEOUT), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .n_cnt(n_cnt), .m_cnt(m_cnt), .k_frac(k_frac), .c_cnt(c_cnt),
        .busy(busy), .done(done), .error(error),
        .pll_locked(pll_locked),
        .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
        .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
        .mgmt_waitrequest(waitreq)
    );

    always #5 clk = ~clk;

    assign mgmt_readdata = (corrupt_m && mgmt_address == 6'd4) ?
                           (regs[mgmt_address] ^ 32'd1) : regs[mgmt_address];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: logs completed writes, models the register file, checks stall stability.
    always @(posedge clk) begin
        if (rst_n) begin
            if (mgmt_write || mgmt_read) strobe_cycles++;
            if (done) done_count++;
            if (stab_en && prev_stall) begin
                check("stall_strobe_held", {31'd0, mgmt_write}, 32'd1);
                check("stall_addr_held", {26'd0, mgmt_address}, {26'd0, prev_addr});
                check("stall_data_held", mgmt_writedata, prev_data);
            end
            if (mgmt_write && !waitreq) begin
                log_addr.push_back(mgmt_address);
                log_data.push_back(mgmt_writedata);
                regs[mgmt_address] = mgmt_writedata;
            end
            prev_stall = mgmt_write && waitreq;
            prev_addr  = mgmt_address;
            prev_data  = mgmt_writedata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Slave waitrequest generator: none, random 0..5 stalls, or hold on address 4.
    always @(negedge clk) begin
        if (hold_at_m && mgmt_write && mgmt_address == 6'd4) begin
            waitreq = 1'b1;
        end else if (!stall_en || !(mgmt_write || mgmt_read)) begin
            waitreq = 1'b0;
            armed = 1'b0;
        end else if (!armed) begin
            stall_left = $urandom_range(0, 5);
            armed = 1'b1;
            waitreq = (stall_left != 0);
        end else begin
            if (stall_left > 0) stall_left--;
            waitreq = (stall_left != 0);
        end
    end

    task automatic issue_req(input logic [17:0] n);
        @(negedge clk);
        n_cnt  = n;
        m_cnt  = 18'h00808;
        k_frac = 32'h80000000;
        c_cnt  = {18'h20101, 18'h00404, 18'h00202};
        req    = 1'b1;
        @(negedge clk);
        req    = 1'b0;
    endtask

    task automatic wait_writes(input int target);
        int g = 0;
        while (log_addr.size() < target && g < 400) begin
            @(posedge clk); #1; g++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 300) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_count"}, log_addr.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_addr%0d", tag, i), {26'd0, log_addr[i]}, {26'd0, exp_a[i]});
            check($sformatf("%s_data%0d", tag, i), log_data[i], exp_d[i]);
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    initial begin
        int n;
        int g;
        logic seen2;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_write", {31'd0, mgmt_write}, 32'd0);
        check("rst_read", {31'd0, mgmt_read}, 32'd0);
        check("rst_addr", {26'd0, mgmt_address}, 32'd0);
        check("rst_wdata", mgmt_writedata, 32'd0);
        rst_n = 1'b1;

        // Basic sequence without stalls; a second req while busy must be ignored
        clear_log();
        done_count = 0;
        issue_req(18'h00404);
        check("busy_after_req", {31'd0, busy}, 32'd1);
        issue_req(18'h3FFFF);
        wait_writes(8);
        repeat (30) @(negedge clk);
        pll_locked = 1'b1;
        wait_done(n);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
        check("done_latency_in_window", {31'd0, ((29 + n) >= 31) && ((29 + n) <= 33)}, 32'd1);
        repeat (3) @(negedge clk);
        check("done_once", done_count, 32'd1);
        check("done_dropped", {31'd0, done}, 32'd0);
        check("error_clear_after_ok", {31'd0, error}, 32'd0);
        check_seq("seq_nostall");

        // Random waitrequest stalls
        clear_log();
        pll_locked = 1'b0;
        stall_en = 1'b1;
        stab_en = 1'b1;
        issue_req(18'h00404);
        wait_writes(8);
        @(negedge clk);
        pll_locked = 1'b1;
        wait_done(n);
        check("stall_done", {31'd0, done}, 32'd1);
        stall_en = 1'b0;
        stab_en = 1'b0;
        repeat (3) @(negedge clk);
        check_seq("seq_stall");

        // Lock timeout: error exactly LOCK_TIMEOUT cycles after START completes
        clear_log();
        pll_locked = 1'b0;
        issue_req(18'h00404);
        wait_writes(8);
        n = 0;
        while (!error && n < 300) begin
            @(posedge clk); #1; n++;
        end
        check("timeout_error", {31'd0, error}, 32'd1);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        check("timeout_cycles", n, 32'd100);
        repeat (3) @(negedge clk);
        check("error_sticky", {31'd0, error}, 32'd1);
        clear_log();
        issue_req(18'h00404);
        check("error_cleared_by_req", {31'd0, error}, 32'd0);
        pll_locked = 1'b1;
        wait_writes(8);
        wait_done(n);
        check("recover_done", {31'd0, done}, 32'd1);
        repeat (3) @(negedge clk);

        // Reset asserted while WR_M is stalled
        clear_log();
        pll_locked = 1'b0;
        hold_at_m = 1'b1;
        issue_req(18'h00404);
        g = 0;
        while (!(mgmt_write && mgmt_address == 6'd4) && g < 100) begin
            @(negedge clk); g++;
        end
        repeat (3) @(negedge clk);
        check("held_wr_m_strobe", {31'd0, mgmt_write}, 32'd1);
        check("held_wr_m_data", mgmt_writedata, 32'h808);
        rst_n = 1'b0;
        #1;
        check("midrst_write", {31'd0, mgmt_write}, 32'd0);
        check("midrst_read", {31'd0, mgmt_read}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hold_at_m = 1'b0;
        strobe_cycles = 0;
        repeat (20) @(negedge clk);
        check("postrst_no_bus", strobe_cycles, 32'd0);
        check("postrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_writes_logged", log_addr.size(), 32'd2);

`ifdef PLL_RECONF_READBACK_EN
        // Readback of M returns 0x809: abort with error, no START write
        clear_log();
        corrupt_m = 1'b1;
        issue_req(18'h00404);
        g = 0;
        while (busy && g < 400) begin
            @(negedge clk); g++;
        end
        check("rb_error", {31'd0, error}, 32'd1);
        check("rb_busy", {31'd0, busy}, 32'd0);
        check("rb_write_count", log_addr.size(), 32'd4);
        seen2 = 1'b0;
        foreach (log_addr[i]) if (log_addr[i] == 6'd2) seen2 = 1'b1;
        check("rb_no_start", {31'd0, seen2}, 32'd0);
        corrupt_m = 1'b0;
`else
        seen2 = 1'b0;
        check("no_readback_read_low", {31'd0, mgmt_read}, {31'd0, seen2});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
